mestpro_job_sequencer: RTL and testbench

//  Controller that sequences the MestPro accumulator processor. Accepts one ALU job {OP, A, B}

---
 rtl/mestpro_job_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_mestpro_job_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mestpro_job_sequencer.sv
// Job sequencer for the MestPro accumulator processor: turns one {OP,A,B}
// request into an instruction stream and returns ACC over a response port.
//
// Ports:
//   CLK, RESET (async, active-low)      clock and reset shared with the processor
//   REQ_VALID/REQ_READY/REQ_OP/A/B       job request handshake and fields
//   RSP_VALID/RSP_READY/RSP_DATA/ERR     result handshake, data and illegal-op flag
//   BUSY                                 high whenever not idle
//   INSTRUCTION, IN_DATA                 instruction and data to the processor
//   OUT_DATA                             processor output port
module mestpro_job_sequencer #(
    parameter int OUT_LAT = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [2:0] REQ_OP,
    input  logic [7:0] REQ_A,
    input  logic [7:0] REQ_B,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic [7:0] RSP_DATA,
    output logic       RSP_ERR,
    output logic       BUSY,
    output logic [7:0] INSTRUCTION,
    output logic [7:0] IN_DATA,
    input  logic [7:0] OUT_DATA
);

    localparam int CW = (OUT_LAT > 1) ? $clog2(OUT_LAT) : 1;

    localparam logic [7:0] I_NOP = 8'd0;
    localparam logic [7:0] I_LDA = 8'd1;
    localparam logic [7:0] I_ADD = 8'd2;
    localparam logic [7:0] I_XOR = 8'd6;
    localparam logic [7:0] I_OUT = 8'd7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR_LD,
        S_CLR_X,
        S_LD_A,
        S_ADD_A,
        S_LD_B,
        S_EXEC,
        S_OUT,
        S_WAIT,
        S_REJ,
        S_DONE
    } state_t;

    state_t          state, state_d;
    logic [2:0]      op_q, op_d;
    logic [7:0]      a_q, a_d;
    logic [7:0]      b_q, b_d;
    logic [7:0]      sh_q, sh_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rsp_valid_d;
    logic [7:0]      rsp_data_d;
    logic            rsp_err_d;
    logic            busy_d;
    logic [7:0]      instr_d;
    logic [7:0]      in_data_d;
    logic            op_legal;

    assign REQ_READY = (state == S_IDLE);

    always_comb begin
        op_legal = 1'b0;
        unique case (REQ_OP)
            3'd2, 3'd3, 3'd4, 3'd5, 3'd6: op_legal = 1'b1;
            default:                      op_legal = 1'b0;
        endcase
    end

    // Outputs are registered, so each state computes the values that the
    // processor sees during the following state.
    always_comb begin
        state_d     = state;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        rsp_valid_d = RSP_VALID;
        rsp_data_d  = RSP_DATA;
        rsp_err_d   = RSP_ERR;
        instr_d     = I_NOP;
        in_data_d   = IN_DATA;

        unique case (state)
            S_IDLE: begin
                if (REQ_VALID) begin
                    op_d = REQ_OP;
                    a_d  = REQ_A;
                    b_d  = REQ_B;
                    if (op_legal) begin
                        state_d   = S_CLR_LD;
                        instr_d   = I_LDA;
                        in_data_d = sh_q;
                    end else begin
                        state_d = S_REJ;
                    end
                end
            end
            // Operand reg holds SH == ACC, so the XOR leaves ACC at zero.
            S_CLR_LD: begin
                state_d = S_CLR_X;
                instr_d = I_XOR;
            end
            S_CLR_X: begin
                state_d   = S_LD_A;
                instr_d   = I_LDA;
                in_data_d = a_q;
            end
            S_LD_A: begin
                state_d = S_ADD_A;
                instr_d = I_ADD;
            end
            S_ADD_A: begin
                state_d   = S_LD_B;
                instr_d   = I_LDA;
                in_data_d = b_q;
            end
            S_LD_B: begin
                state_d = S_EXEC;
                instr_d = {5'd0, op_q};
            end
            S_EXEC: begin
                state_d = S_OUT;
                instr_d = I_OUT;
            end
            S_OUT: begin
                state_d = S_WAIT;
                cnt_d   = CW'(OUT_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = S_DONE;
                    rsp_data_d  = OUT_DATA;
                    sh_d        = OUT_DATA;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_REJ: begin
                state_d     = S_DONE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_data_d  = 8'd0;
            end
            S_DONE: begin
                if (RSP_READY) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= S_IDLE;
            op_q        <= 3'd0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            sh_q        <= 8'd0;
            cnt_q       <= '0;
            RSP_VALID   <= 1'b0;
            RSP_DATA    <= 8'd0;
            RSP_ERR     <= 1'b0;
            BUSY        <= 1'b0;
            INSTRUCTION <= I_NOP;
            IN_DATA     <= 8'd0;
        end else begin
            state       <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            RSP_VALID   <= rsp_valid_d;
            RSP_DATA    <= rsp_data_d;
            RSP_ERR     <= rsp_err_d;
            BUSY        <= busy_d;
            INSTRUCTION <= instr_d;
            IN_DATA     <= in_data_d;
        end
    end

endmodule

// File: tb/tb_mestpro_job_sequencer.sv
// Directed bench for mestpro_job_sequencer with a small MestPro processor
// model (operand reg loaded by LDA, ACC op= operand, OUT registers ACC).
module tb_mestpro_job_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [2:0] REQ_OP = 3'd0;
    logic [7:0] REQ_A = 8'd0;
    logic [7:0] REQ_B = 8'd0;
    logic       RSP_VALID;
    logic       RSP_READY = 1'b0;
    logic [7:0] RSP_DATA;
    logic       RSP_ERR;
    logic       BUSY;
    logic [7:0] INSTRUCTION;
    logic [7:0] IN_DATA;
    logic [7:0] OUT_DATA;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    mestpro_job_sequencer #(.OUT_LAT(1)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_OP(REQ_OP),
        .REQ_A(REQ_A),
        .REQ_B(REQ_B),
        .RSP_VALID(RSP_VALID),
        .RSP_READY(RSP_READY),
        .RSP_DATA(RSP_DATA),
        .RSP_ERR(RSP_ERR),
        .BUSY(BUSY),
        .INSTRUCTION(INSTRUCTION),
        .IN_DATA(IN_DATA),
        .OUT_DATA(OUT_DATA)
    );

    logic [7:0] acc, opr;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc      <= 8'd0;
            opr      <= 8'd0;
            OUT_DATA <= 8'd0;
        end else begin
            case (INSTRUCTION)
                8'd1: opr <= IN_DATA;
                8'd2: acc <= acc + opr;
                8'd3: acc <= acc - opr;
                8'd4: acc <= acc & opr;
                8'd5: acc <= acc | opr;
                8'd6: acc <= acc ^ opr;
                8'd7: OUT_DATA <= acc;
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] rst_vec();
        return {RSP_VALID, RSP_ERR, BUSY, REQ_READY,
                RSP_DATA, INSTRUCTION, IN_DATA};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!REQ_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("req_ready", {63'd0, REQ_READY}, 64'd1);
    endtask

    task automatic do_job(input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] sh,
                          input logic [7:0] exp, input int hold);
        logic [63:0] trace;
        logic [23:0] ind;
        logic        stable;
        int          n;
        wait_ready();
        REQ_OP    = op;
        REQ_A     = a;
        REQ_B     = b;
        REQ_VALID = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        trace = '0;
        ind   = '0;
        for (int k = 0; k < 8; k++) begin
            trace = {trace[55:0], INSTRUCTION};
            if (k == 0) ind[23:16] = IN_DATA;
            if (k == 2) ind[15:8]  = IN_DATA;
            if (k == 4) ind[7:0]   = IN_DATA;
            @(negedge CLK);
        end
        n = 8;
        while (!RSP_VALID && n < 30) begin
            @(negedge CLK);
            n++;
        end
        chk("trace", trace, {8'd1, 8'd6, 8'd1, 8'd2, 8'd1,
                             5'd0, op, 8'd7, 8'd0});
        chk("in_data", {40'd0, ind}, {40'd0, sh, a, b});
        chk("latency", 64'(n), 64'd8);
        chk("rsp_data", {56'd0, RSP_DATA}, {56'd0, exp});
        chk("rsp_err", {63'd0, RSP_ERR}, 64'd0);
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                REQ_OP    = 3'd2;
                REQ_A     = 8'd1;
                REQ_B     = 8'd1;
                REQ_VALID = 1'b1;
            end
            if (h == 3) REQ_VALID = 1'b0;
            @(negedge CLK);
            if (!(RSP_VALID && RSP_DATA == exp && !RSP_ERR &&
                  !REQ_READY && BUSY)) stable = 1'b0;
        end
        REQ_VALID = 1'b0;
        if (hold > 0) chk("hold_stable", {63'd0, stable}, 64'd1);
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        chk("release", {62'd0, RSP_VALID, BUSY}, 64'd0);
    endtask

    initial begin
        #1;
        chk("reset_vals", {36'd0, rst_vec()}, {36'd0, 4'b0001, 24'd0});
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        do_job(3'd2, 8'd5,   8'd3,   8'd0,   8'd8,   0);
        do_job(3'd2, 8'd255, 8'd2,   8'd8,   8'd1,   0);
        do_job(3'd3, 8'd29,  8'd33,  8'd1,   8'd252, 0);
        do_job(3'd4, 8'hF0,  8'h0F,  8'd252, 8'h00,  0);
        do_job(3'd5, 8'hAA,  8'h55,  8'h00,  8'hFF,  0);
        do_job(3'd6, 8'hAA,  8'hAA,  8'hFF,  8'h00,  0);

        wait_ready();
        REQ_OP    = 3'd1;
        REQ_A     = 8'd9;
        REQ_B     = 8'd9;
        REQ_VALID = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        chk("ill_e0", {61'd0, RSP_VALID, BUSY, |INSTRUCTION}, 64'b010);
        @(negedge CLK);
        chk("ill_e1", {53'd0, RSP_VALID, RSP_ERR, RSP_DATA, |INSTRUCTION},
            {53'd0, 1'b1, 1'b1, 8'd0, 1'b0});
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        chk("ill_release", {62'd0, RSP_VALID, REQ_READY}, 64'b01);

        do_job(3'd2, 8'd14, 8'd0,  8'd0,  8'd14, 0);
        do_job(3'd2, 8'd10, 8'd20, 8'd14, 8'd30, 5);

        wait_ready();
        REQ_OP    = 3'd3;
        REQ_A     = 8'd10;
        REQ_B     = 8'd8;
        REQ_VALID = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        chk("in_ld_b", {48'd0, INSTRUCTION, IN_DATA}, {48'd0, 8'd1, 8'd8});
        RESET = 1'b0;
        #1;
        chk("mid_reset", {36'd0, rst_vec()}, {36'd0, 4'b0001, 24'd0});
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        chk("no_rsp", {62'd0, RSP_VALID, BUSY}, 64'd0);

        do_job(3'd3, 8'd10, 8'd8, 8'd0, 8'd2, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
